// File: rtl/lsu_mem_access.sv
// Load/store access unit: one request at a time over a req/gnt/rvalid data-memory bus.
// Optional misalignment trap compiled in with `define LSU_MISALIGN_TRAP_EN.
module lsu_mem_access (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [2:0]  req_funct3_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [4:0]  req_rd_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_data_o,
  output logic [4:0]  rsp_rd_o,
  output logic        rsp_we_o
`ifdef LSU_MISALIGN_TRAP_EN
  ,
  output logic        rsp_misalign_o
`endif
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  state_t      state, state_nxt;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [4:0]  rd_q;
  logic        is_req;
  logic        trap;

  // funct3[1:0]: 00 byte, 01 half, 10/11 word; a half only looks at off[1]
  function automatic logic [3:0] be_gen(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b00:   be_gen = 4'b0001 << off;
      2'b01:   be_gen = off[1] ? 4'b1100 : 4'b0011;
      default: be_gen = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] wdata_gen(input logic [1:0] size, input logic [31:0] wd);
    case (size)
      2'b00:   wdata_gen = {4{wd[7:0]}};
      2'b01:   wdata_gen = {2{wd[15:0]}};
      default: wdata_gen = wd;
    endcase
  endfunction

  function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [1:0] off,
                                           input logic [31:0] rdata);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'd0:    b = rdata[7:0];
      2'd1:    b = rdata[15:8];
      2'd2:    b = rdata[23:16];
      default: b = rdata[31:24];
    endcase
    h = off[1] ? rdata[31:16] : rdata[15:0];
    case (f3)
      3'b000:  load_ext = {{24{b[7]}}, b};
      3'b001:  load_ext = {{16{h[15]}}, h};
      3'b100:  load_ext = {24'b0, b};
      3'b101:  load_ext = {16'b0, h};
      default: load_ext = rdata;
    endcase
  endfunction

`ifdef LSU_MISALIGN_TRAP_EN
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    misaligned = (size == 2'b01) ? off[0] : (size[1] && (off != 2'b00));
  endfunction

  assign trap = misaligned(req_funct3_i[1:0], req_addr_i[1:0]);
`else
  assign trap = 1'b0;
`endif

  // Bus side is decoded from state and latched request only
  always_comb begin
    is_req      = (state == REQ);
    req_ready_o = (state == IDLE);
    rsp_valid_o = (state == RESP);
    mem_req_o   = is_req;
    mem_we_o    = is_req & we_q;
    mem_addr_o  = is_req ? {addr_q[31:2], 2'b00} : 32'b0;
    mem_be_o    = is_req ? be_gen(f3_q[1:0], addr_q[1:0]) : 4'b0;
    mem_wdata_o = (is_req && we_q) ? wdata_gen(f3_q[1:0], wdata_q) : 32'b0;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (req_valid_i) state_nxt = trap ? RESP : REQ;
      REQ:  if (mem_gnt_i) state_nxt = we_q ? RESP : WAIT;
      WAIT: if (mem_rvalid_i) state_nxt = RESP;
      RESP: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Request fields carry no reset; they are only observed after a new accept
  always_ff @(posedge clk) begin
    if (state == IDLE && req_valid_i) begin
      we_q    <= req_we_i;
      f3_q    <= req_funct3_i;
      addr_q  <= req_addr_i;
      wdata_q <= req_wdata_i;
      rd_q    <= req_rd_i;
    end
  end

  logic mis_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_data_o <= 32'b0;
      rsp_rd_o   <= 5'b0;
      rsp_we_o   <= 1'b0;
      mis_q      <= 1'b0;
    end else if (state == IDLE && req_valid_i && trap) begin
      rsp_data_o <= 32'b0;
      rsp_rd_o   <= req_rd_i;
      rsp_we_o   <= 1'b0;
      mis_q      <= 1'b1;
    end else if (state == REQ && mem_gnt_i && we_q) begin
      rsp_data_o <= 32'b0;
      rsp_rd_o   <= rd_q;
      rsp_we_o   <= 1'b0;
      mis_q      <= 1'b0;
    end else if (state == WAIT && mem_rvalid_i) begin
      rsp_data_o <= load_ext(f3_q, addr_q[1:0], mem_rdata_i);
      rsp_rd_o   <= rd_q;
      rsp_we_o   <= 1'b1;
      mis_q      <= 1'b0;
    end
  end

`ifdef LSU_MISALIGN_TRAP_EN
  assign rsp_misalign_o = mis_q;
`else
  logic unused_mis;
  assign unused_mis = mis_q;
`endif

endmodule

// File: tb/tb_lsu_mem_access.sv
// Directed bench for lsu_mem_access with a transaction-level expectation model.
// Exercises the misalignment trap when built with `define LSU_MISALIGN_TRAP_EN.
module tb_lsu_mem_access;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid_i, req_we_i;
  logic [2:0]  req_funct3_i;
  logic [31:0] req_addr_i, req_wdata_i;
  logic [4:0]  req_rd_i;
  logic        req_ready_o, mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [3:0]  mem_be_o;
  logic        mem_gnt_i, mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        rsp_valid_o, rsp_we_o;
  logic [31:0] rsp_data_o;
  logic [4:0]  rsp_rd_o;
`ifdef LSU_MISALIGN_TRAP_EN
  logic        rsp_misalign_o;
`endif

  always #5 clk = ~clk;

  lsu_mem_access dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
    .req_funct3_i(req_funct3_i), .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
    .req_rd_i(req_rd_i),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_data_o(rsp_data_o), .rsp_rd_o(rsp_rd_o),
    .rsp_we_o(rsp_we_o)
`ifdef LSU_MISALIGN_TRAP_EN
    , .rsp_misalign_o(rsp_misalign_o)
`endif
  );

  int nvec = 0;
  int nerr = 0;

  // Model state: the request in flight and what each output must show this cycle
  logic        chk_en = 1'b0;
  logic        m_ready, m_req, m_rsp, m_rwe, m_mis;
  logic [31:0] m_data;
  logic [4:0]  m_rd;
  logic        c_we;
  logic [2:0]  c_f3;
  logic [31:0] c_addr, c_wd;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic int nbytes(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic int lane(input logic [2:0] f3, input logic [31:0] addr);
    int n = nbytes(f3);
    if (n == 1) return int'(addr[1:0]);
    if (n == 2) return addr[1] ? 2 : 0;
    return 0;
  endfunction

  function automatic logic [3:0] exp_be(input logic [2:0] f3, input logic [31:0] addr);
    int m;
    m = ((1 << nbytes(f3)) - 1) << lane(f3, addr);
    return m[3:0];
  endfunction

  function automatic logic [31:0] exp_wd(input logic [2:0] f3, input logic [31:0] wd);
    logic [31:0] o;
    logic [31:0] s;
    int n = nbytes(f3);
    for (int k = 0; k < 4; k++) begin
      s = wd >> (8 * (k % n));
      o[8*k +: 8] = s[7:0];
    end
    return o;
  endfunction

  function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] addr,
                                           input logic [31:0] rdata);
    int n = nbytes(f3);
    logic [31:0] v, mask;
    if (n == 4) return rdata;
    v = rdata >> (8 * lane(f3, addr));
    mask = (32'h1 << (8 * n)) - 32'h1;
    v = v & mask;
    if (!f3[2] && v[8*n-1]) v = v | ~mask;
    return v;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("req_ready", {31'b0, req_ready_o}, {31'b0, m_ready});
      chk("mem_req", {31'b0, mem_req_o}, {31'b0, m_req});
      chk("rsp_valid", {31'b0, rsp_valid_o}, {31'b0, m_rsp});
      if (m_req) begin
        chk("mem_we", {31'b0, mem_we_o}, {31'b0, c_we});
        chk("mem_addr", mem_addr_o, c_addr & 32'hFFFF_FFFC);
        chk("mem_be", {28'b0, mem_be_o}, {28'b0, exp_be(c_f3, c_addr)});
        if (c_we) chk("mem_wdata", mem_wdata_o, exp_wd(c_f3, c_wd));
      end
      if (m_rsp) begin
        chk("rsp_data", rsp_data_o, m_data);
        chk("rsp_rd", {27'b0, rsp_rd_o}, {27'b0, m_rd});
        chk("rsp_we", {31'b0, rsp_we_o}, {31'b0, m_rwe});
`ifdef LSU_MISALIGN_TRAP_EN
        chk("rsp_misalign", {31'b0, rsp_misalign_o}, {31'b0, m_mis});
`endif
      end
    end
  end

  task automatic run(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                     input logic [31:0] wd, input logic [4:0] rd, input int gd,
                     input int rvd, input logic [31:0] rdata);
    req_valid_i = 1'b1; req_we_i = we; req_funct3_i = f3;
    req_addr_i = addr; req_wdata_i = wd; req_rd_i = rd;
    c_we = we; c_f3 = f3; c_addr = addr; c_wd = wd;
    @(posedge clk); #1;
    req_valid_i = 1'b0; m_ready = 1'b0; m_req = 1'b1;
    for (int i = 0; i < gd; i++) begin @(posedge clk); #1; end
    mem_gnt_i = 1'b1;
    @(posedge clk); #1;
    mem_gnt_i = 1'b0; m_req = 1'b0;
    if (!we) begin
      for (int i = 0; i < rvd; i++) begin @(posedge clk); #1; end
      mem_rvalid_i = 1'b1; mem_rdata_i = rdata;
      @(posedge clk); #1;
      mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0;
    end
    m_rsp = 1'b1; m_rd = rd; m_rwe = !we; m_mis = 1'b0;
    m_data = we ? 32'h0 : exp_load(f3, addr, rdata);
    @(posedge clk); #1;
    m_rsp = 1'b0; m_ready = 1'b1;
  endtask

`ifdef LSU_MISALIGN_TRAP_EN
  task automatic run_trap(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [4:0] rd);
    req_valid_i = 1'b1; req_we_i = we; req_funct3_i = f3;
    req_addr_i = addr; req_wdata_i = 32'h5555_AAAA; req_rd_i = rd;
    @(posedge clk); #1;
    req_valid_i = 1'b0; m_ready = 1'b0;
    m_rsp = 1'b1; m_data = 32'h0; m_rd = rd; m_rwe = 1'b0; m_mis = 1'b1;
    @(posedge clk); #1;
    m_rsp = 1'b0; m_ready = 1'b1; m_mis = 1'b0;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr + 1);
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; req_valid_i = 1'b0; req_we_i = 1'b0; req_funct3_i = 3'b0;
    req_addr_i = 32'h0; req_wdata_i = 32'h0; req_rd_i = 5'h0;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0;
    m_ready = 1'b1; m_req = 1'b0; m_rsp = 1'b0; m_rwe = 1'b0; m_mis = 1'b0;
    m_data = 32'h0; m_rd = 5'h0;
    c_we = 1'b0; c_f3 = 3'b0; c_addr = 32'h0; c_wd = 32'h0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk_en = 1'b1;
    chk("reset_rsp_data", rsp_data_o, 32'h0);

    // Hand-computed pins on the model itself
    chk("pin_lb", exp_load(3'b000, 32'h103, 32'h80AA_BBCC), 32'hFFFF_FF80);
    chk("pin_lhu", exp_load(3'b101, 32'h202, 32'h8001_1234), 32'h0000_8001);
    chk("pin_be_lb", {28'b0, exp_be(3'b000, 32'h103)}, 32'h8);
    chk("pin_be_sh", {28'b0, exp_be(3'b001, 32'h006)}, 32'hC);
    chk("pin_wd_sh", exp_wd(3'b001, 32'hDEAD_BEEF), 32'hBEEF_BEEF);
    chk("pin_wd_sb", exp_wd(3'b000, 32'h1234_5678), 32'h7878_7878);

    run(1'b0, 3'b000, 32'h103, 32'h0, 5'd5, 0, 0, 32'h80AA_BBCC);
    chk("lb_data_lit", rsp_data_o, 32'hFFFF_FF80);
    chk("lb_we_lit", {31'b0, rsp_we_o}, 32'h1);
    run(1'b0, 3'b101, 32'h202, 32'h0, 5'd6, 0, 0, 32'h8001_1234);
    chk("lhu_data_lit", rsp_data_o, 32'h0000_8001);
    run(1'b1, 3'b001, 32'h006, 32'hDEAD_BEEF, 5'd9, 3, 0, 32'h0);
    chk("sh_data_lit", rsp_data_o, 32'h0);
    run(1'b1, 3'b000, 32'h001, 32'h1234_5678, 5'd10, 1, 0, 32'h0);
    run(1'b0, 3'b001, 32'h002, 32'h0, 5'd11, 0, 2, 32'h9ABC_1234);
    chk("lh_data_lit", rsp_data_o, 32'hFFFF_9ABC);
    run(1'b0, 3'b100, 32'h001, 32'h0, 5'd12, 2, 1, 32'h0000_F100);
    chk("lbu_data_lit", rsp_data_o, 32'h0000_00F1);
    run(1'b1, 3'b010, 32'h020, 32'hCAFE_F00D, 5'd13, 0, 0, 32'h0);
    run(1'b0, 3'b111, 32'h030, 32'h0, 5'd14, 0, 0, 32'h8765_4321);
    chk("f3_111_lit", rsp_data_o, 32'h8765_4321);
    run(1'b1, 3'b011, 32'h034, 32'h0BAD_F00D, 5'd15, 1, 0, 32'h0);
    run(1'b0, 3'b010, 32'h044, 32'h0, 5'd16, 0, 0, 32'h1357_9BDF);

    // Reset while a load waits for rvalid, then a stray rvalid in IDLE
    req_valid_i = 1'b1; req_we_i = 1'b0; req_funct3_i = 3'b010;
    req_addr_i = 32'h40; req_rd_i = 5'd7;
    c_we = 1'b0; c_f3 = 3'b010; c_addr = 32'h40;
    @(posedge clk); #1;
    req_valid_i = 1'b0; m_ready = 1'b0; m_req = 1'b1; mem_gnt_i = 1'b1;
    @(posedge clk); #1;
    mem_gnt_i = 1'b0; m_req = 1'b0; rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1; m_ready = 1'b1;
    chk("rst_rsp_data", rsp_data_o, 32'h0);
    chk("rst_rsp_rd", {27'b0, rsp_rd_o}, 32'h0);
    chk("rst_rsp_we", {31'b0, rsp_we_o}, 32'h0);
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0;
    @(posedge clk); #1;
    run(1'b0, 3'b010, 32'h010, 32'h0, 5'd8, 0, 0, 32'h2468_ACE0);
    chk("lw_after_rst_lit", rsp_data_o, 32'h2468_ACE0);

`ifdef LSU_MISALIGN_TRAP_EN
    run_trap(1'b0, 3'b010, 32'h002, 5'd3);
    run_trap(1'b1, 3'b001, 32'h005, 5'd4);
    run(1'b0, 3'b001, 32'h006, 32'h0, 5'd2, 0, 0, 32'h8123_4567);
    chk("aligned_lh_lit", rsp_data_o, 32'hFFFF_8123);
`else
    run(1'b0, 3'b010, 32'h002, 32'h0, 5'd3, 0, 0, 32'h1122_3344);
    chk("mis_lw_lit", rsp_data_o, 32'h1122_3344);
    run(1'b0, 3'b001, 32'h003, 32'h0, 5'd4, 0, 0, 32'h8123_4567);
    chk("mis_lh_lit", rsp_data_o, 32'hFFFF_8123);
`endif

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/lsu_mem_access.md
# lsu_mem_access

Load/store access unit between the execute stage and the data-memory bus. It is the producer of the memory-read value consumed by the writeback mux. It takes one load or store request at a time and drives a req/gnt/rvalid data-memory handshake. For loads, it extracts and sign- or zero-extends the addressed byte, halfword or word and returns it with the destination register index. For stores, it generates byte enables and lane-shifted write data.

## Interface
- No parameters; all data and address widths are 32 bits, and byte-enable width is 4.
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `req_valid_i` in 1: execute stage presents a request.
- `req_ready_o` out 1: unit can accept a request (high only in IDLE).
- `req_we_i` in 1: 1 = store, 0 = load.
- `req_funct3_i` in 3: RV32I funct3.
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
- `req_addr_i` in 32: byte address from the ALU.
- `req_wdata_i` in 32: store data (rs2).
- `req_rd_i` in 5: destination register index.
- `mem_req_o` out 1: bus request.
- `mem_we_o` out 1: bus write.
- `mem_addr_o` out 32: word-aligned address ({addr[31:2],2'b00}).
- `mem_be_o` out 4: byte enables.
- `mem_wdata_o` out 32: lane-shifted write data.
- `mem_gnt_i` in 1: bus accepted the request this cycle.
- `mem_rvalid_i` in 1: read data valid.
- `mem_rdata_i` in 32: read data word.
- `rsp_valid_o` out 1: one-cycle completion pulse.
- `rsp_data_o` out 32: extended load data; 0 for stores.
- `rsp_rd_o` out 5: rd of the completed access.
- `rsp_we_o` out 1: 1 if the completion is a load (register write needed).
- `rsp_misalign_o` out 1: misaligned-access flag. Present only when the misalignment check is compiled in; see Configuration.

## Operation
- FSM states: IDLE, REQ, WAIT, RESP.
- **IDLE:**
  - `req_ready_o`=1.
  - When `req_valid_i`, latch we/funct3/addr/wdata/rd, then go to REQ.
- **REQ:**
  - `mem_req_o`=1, with address, we, be and wdata driven from the latched values.
  - Outputs hold stable until `mem_gnt_i`.
  - On gnt: a store goes to RESP; a load goes to WAIT.
- **WAIT:** on `mem_rvalid_i`, capture `mem_rdata_i` and go to RESP.
  - `mem_rvalid_i` arriving in the same cycle as gnt is not legal; the bus delivers it at least one cycle later.
- **RESP:** `rsp_valid_o`=1 for exactly one cycle, then return to IDLE.
- **Byte enables** (off = addr[1:0]):
  - Byte access: 4'b0001<<off.
  - Half access: 4'b0011<<off.
  - Word access: 4'b1111.
- **Write data:**
  - SB: {4{wdata[7:0]}}.
  - SH: {2{wdata[15:0]}}.
  - SW: wdata.
- **Load extraction:**
  - Byte = rdata[8*off+7 : 8*off]; half = rdata[16*off[1]+15 : 16*off[1]].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- **Unsupported funct3** (011, 110, 111): treated as LW/SW.
- **Reset** (rst_n=0 at an edge) in any state, including mid-handshake:
  - Next state is IDLE; all outputs go to 0, and `req_ready_o`=1 after reset.
  - A pending bus transaction is abandoned; a late `mem_rvalid_i` in IDLE is ignored.

## Timing
- Request accepted at edge N; `mem_req_o` high from cycle N+1.
- Store with immediate gnt: `rsp_valid_o` in cycle N+2.
- Load with gnt at N+1 and rvalid at N+2: `rsp_valid_o` in cycle N+3.
- Each gnt wait cycle and each rvalid wait cycle adds one cycle.
- All outputs are registered or decoded only from state plus latched values, with no combinational path from `mem_*_i` to `mem_*_o`.
- `rsp_data_o`/`rsp_rd_o`/`rsp_we_o` are valid only while `rsp_valid_o`=1; otherwise they hold their last value.
- Throughput: at most one access in flight, and there is no back-to-back acceptance. `req_ready_o`=0 from REQ through RESP.

## Configuration
- Macro: `LSU_MISALIGN_TRAP_EN`.
- **Defined:**
  - A half access with addr[0]=1, or a word access with addr[1:0]≠0, is detected in IDLE at acceptance.
  - The FSM goes directly to RESP with no bus request.
  - It pulses `rsp_valid_o` with `rsp_misalign_o`=1, `rsp_we_o`=0 and `rsp_data_o`=0.
  - `rsp_misalign_o` is 0 on all other completions.
- **Undefined:**
  - The port `rsp_misalign_o` is absent.
  - The offending low address bits are ignored:
    - A misaligned word uses the aligned word.
    - A misaligned half uses off[1] only.
  - The access proceeds normally.

## Test plan
- Reset: hold rst_n=0 for 2 cycles → `mem_req_o`=0, `rsp_valid_o`=0, `req_ready_o`=1.
- LB at addr 0x103, rdata=0x80AA_BBCC, gnt immediate, rvalid +1 cycle → `mem_addr_o`=0x100, `mem_be_o`=4'b1000, `rsp_data_o`=0xFFFF_FF80, `rsp_we_o`=1, rsp at N+3.
- LHU at addr 0x202, rdata=0x8001_1234 → `rsp_data_o`=0x0000_8001.
- SH at addr 0x006, wdata=0xDEAD_BEEF, gnt delayed 3 cycles → `mem_be_o`=4'b1100, `mem_wdata_o`=0xBEEF_BEEF, outputs stable during the wait, rsp at N+5 with `rsp_data_o`=0.
- Load stalled in WAIT, rst_n=0 for one edge → state IDLE, `mem_req_o`=0. A subsequent stray rvalid produces no rsp; the next LW at 0x10 completes normally.
- With `LSU_MISALIGN_TRAP_EN`, LW at 0x2 → no `mem_req_o`, `rsp_valid_o`=1 at N+1 with `rsp_misalign_o`=1. Without the macro, the same request reads word 0x0.
